step_dir_move_decoder: RTL
==========================

Name: step_dir_move_decoder

Overview:
- Receive-side monitor for the stepper motion interface (step_x/direction_x/step_y/direction_y/magnet) driven by the block-movement motor controller.
- Reconstructs carriage position in board cells from the step pulses.
- Converts each magnet-on..magnet-off interval into a (start cell, end cell) move record and queues it in a small FIFO with a valid/ready handshake.
- Used as the closed-loop checker / board-state feeder beside the motor path.

Parameters:
- STEPS_PER_CELL, 200, step pulses per board cell on either axis.
- COLS, 4, board columns; cell index = row*COLS + col.
- ROWS, 5, board rows.
- SYNC_STAGES, 2, flip-flop synchronizer depth on every motor input.
- FIFO_DEPTH, 4, move-record queue depth (power of 2).

Ports:
- i_Clk  in  1  clock
- i_rst_n  in  1  reset
- i_step_x  in  1  X step pulse; one step per rising edge
- i_direction_x  in  1  X direction; 1 = +col, 0 = -col
- i_step_y  in  1  Y step pulse
- i_direction_y  in  1  Y direction; 1 = +row, 0 = -row
- i_magnet  in  1  electromagnet enable
- i_clear  in  1  synchronous re-home: position to cell 0, abort any carry
- o_cell  out  5  current cell index
- o_carrying  out  1  magnet held, move in progress
- o_move_valid  out  1  FIFO head valid
- i_move_ready  in  1  consumer accepts head
- o_move_start  out  5  head record start cell
- o_move_end  out  5  head record end cell
- o_err_range  out  1  sticky; a step tried to leave the board
- o_err_overflow  out  1  sticky; a record was dropped on a full FIFO

Behaviour:
- Reset/clock: reset i_rst_n, asynchronous, active-low; clock i_Clk. On reset, all outputs are 0, position is cell 0 with sub-step 0, FIFO is empty, and state is S_IDLE. Reset mid-carry discards the carry.
- Synchronization: all five motor inputs pass through SYNC_STAGES flops plus one edge-detect flop.
  - Direction is sampled from the same synchronizer stage as its step, on the step's rising edge.
  - o_cell updates SYNC_STAGES+1 cycles after the raw step edge that completes a cell (3 cycles at default).
- Per axis: sub-step counter 0..STEPS_PER_CELL-1 and cell coordinate 0..COLS-1 (X) or 0..ROWS-1 (Y).
  - +step at STEPS_PER_CELL-1: sub-step goes to 0 and coordinate increments.
  - -step at 0: sub-step goes to STEPS_PER_CELL-1 and coordinate decrements.
  - A step that would move below coordinate 0 or above the last cell: position holds and o_err_range is set. It stays set until i_clear or reset.
- X and Y steps in the same cycle are both applied.
- State machine:
  - S_IDLE: on magnet rising edge, latch the start cell from the registered o_cell and go to S_CARRY.
  - S_CARRY: o_carrying = 1. On magnet falling edge, go to S_PUSH.
  - S_PUSH: one cycle. The end cell is the registered o_cell after any step applied in the falling-edge cycle. Write {start, end} into the FIFO, then go to S_IDLE.
- A start == end record is still pushed (a zero-length move is reported).
- FIFO:
  - A pop happens when o_move_valid && i_move_ready.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full; count is unchanged.
  - Push when full without a pop: the record is dropped and o_err_overflow is set (sticky).
  - o_move_start/o_move_end are registered; they show the head and are 0 when empty.
- i_clear:
  - Has priority over steps and magnet edges in the same cycle.
  - Zeroes both axes, returns to S_IDLE, and clears both error flags.
  - Does not flush the FIFO.
  - A magnet edge coincident with i_clear is ignored.
- Widths: the cell index is 5 bits; row*COLS + col is computed combinationally and then registered. The sub-step counter width is $clog2(STEPS_PER_CELL).

Decomposition:
- Package klotski_motion_pkg holds:
  - COLS, ROWS
  - typedef cell_t (logic [4:0])
  - typedef move_rec_t (struct: start cell_t, end cell_t)
  - state_t enum (S_IDLE, S_CARRY, S_PUSH)
- Sub-module step_axis_tracker (params STEPS_PER_CELL, NCELLS, SYNC_STAGES), instantiated twice for X and Y.
  - Contains the synchronizer, edge detect, sub-step and cell counters, and the range-error pulse.
- FIFO stays inline in the top module.

Test Plan:
- Reset, then 200 +X pulses (4 clocks high/4 low) -> o_cell 0->1 three cycles after the 200th raw edge; no error flags.
- Magnet on at cell 1; 200 +X; 200 +Y; magnet off -> one record {1, 6}, o_move_valid = 1; hold i_move_ready = 0 then 1 -> pops once and o_move_valid goes to 0.
- 199 +X then 199 -X -> o_cell stays 0 throughout; 1 -X at cell 0, sub-step 0 -> position holds and o_err_range = 1 until i_clear.
- Five magnet on/off moves with i_move_ready = 0 -> 4 records kept, fifth dropped, o_err_overflow = 1; fifth push coincident with a ready pop -> accepted, no overflow.
- i_clear asserted mid-carry at cell 7 -> o_cell = 0, o_carrying = 0, no record on the later magnet falling edge.
- i_rst_n asserted low asynchronously mid-carry with 2 records queued -> all outputs 0 immediately, FIFO empty after release.

Source files
------------

// File: rtl/step_dir_move_decoder_pkg.sv
// Shared board geometry, cell/move record types and decoder FSM states.
// The cell index is row*COLS + col and always fits in 5 bits.
package klotski_motion_pkg;

  localparam int COLS = 4;
  localparam int ROWS = 5;

  typedef logic [4:0] cell_t;

  typedef struct packed {
    cell_t start_cell;
    cell_t end_cell;
  } move_rec_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CARRY = 2'd1,
    S_PUSH  = 2'd2
  } state_t;

  function automatic cell_t cell_of(input int row, input int col, input int ncols);
    return cell_t'(row * ncols + col);
  endfunction

endpackage

// File: rtl/step_dir_move_decoder_step_axis_tracker.sv
// One motion axis: synchronizes step/direction, counts sub-steps and cells.
// coord_next_o is the post-step coordinate, valid in the cycle the synchronized edge is seen.
module step_axis_tracker #(
  parameter int STEPS_PER_CELL = 200,
  parameter int NCELLS         = 4,
  parameter int SYNC_STAGES    = 2,
  localparam int SW = (STEPS_PER_CELL > 1) ? $clog2(STEPS_PER_CELL) : 1,
  localparam int CW = (NCELLS > 1) ? $clog2(NCELLS) : 1
) (
  input  logic          i_Clk,
  input  logic          i_rst_n,
  input  logic          step_i,
  input  logic          dir_i,
  input  logic          clear_i,
  output logic [CW-1:0] coord_next_o,
  output logic          range_err_o
);

  localparam logic [SW-1:0] SUB_MAX   = SW'(STEPS_PER_CELL - 1);
  localparam logic [CW-1:0] COORD_MAX = CW'(NCELLS - 1);

  logic [SYNC_STAGES-1:0] step_sync_q;
  logic [SYNC_STAGES-1:0] dir_sync_q;
  logic                   step_prev_q;
  logic [SW-1:0]          sub_q, sub_d;
  logic [CW-1:0]          coord_q, coord_d;
  logic                   step_rise;
  logic                   dir_s;

  // Direction is taken from the same stage as the step so both see equal delay.
  assign step_rise = step_sync_q[SYNC_STAGES-1] & ~step_prev_q;
  assign dir_s     = dir_sync_q[SYNC_STAGES-1];

  always_comb begin
    sub_d       = sub_q;
    coord_d     = coord_q;
    range_err_o = 1'b0;
    if (clear_i) begin
      sub_d   = '0;
      coord_d = '0;
    end else if (step_rise) begin
      if (dir_s) begin
        if (sub_q != SUB_MAX) begin
          sub_d = sub_q + 1'b1;
        end else if (coord_q == COORD_MAX) begin
          range_err_o = 1'b1;
        end else begin
          sub_d   = '0;
          coord_d = coord_q + 1'b1;
        end
      end else begin
        if (sub_q != '0) begin
          sub_d = sub_q - 1'b1;
        end else if (coord_q == '0) begin
          range_err_o = 1'b1;
        end else begin
          sub_d   = SUB_MAX;
          coord_d = coord_q - 1'b1;
        end
      end
    end
  end

  assign coord_next_o = coord_d;

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      step_sync_q <= '0;
      dir_sync_q  <= '0;
      step_prev_q <= 1'b0;
      sub_q       <= '0;
      coord_q     <= '0;
    end else begin
      step_sync_q <= (step_sync_q << 1) | SYNC_STAGES'(step_i);
      dir_sync_q  <= (dir_sync_q << 1) | SYNC_STAGES'(dir_i);
      step_prev_q <= step_sync_q[SYNC_STAGES-1];
      sub_q       <= sub_d;
      coord_q     <= coord_d;
    end
  end

endmodule

// File: rtl/step_dir_move_decoder.sv
// Rebuilds carriage cell from step/dir pulses and queues magnet-on..off moves.
// o_cell lags a completing raw step by SYNC_STAGES+1 cycles; a full FIFO drops new records.
module step_dir_move_decoder #(
  parameter int STEPS_PER_CELL = 200,
  parameter int COLS           = klotski_motion_pkg::COLS,
  parameter int ROWS           = klotski_motion_pkg::ROWS,
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       i_Clk,
  input  logic       i_rst_n,
  input  logic       i_step_x,
  input  logic       i_direction_x,
  input  logic       i_step_y,
  input  logic       i_direction_y,
  input  logic       i_magnet,
  input  logic       i_clear,
  output logic [4:0] o_cell,
  output logic       o_carrying,
  output logic       o_move_valid,
  input  logic       i_move_ready,
  output logic [4:0] o_move_start,
  output logic [4:0] o_move_end,
  output logic       o_err_range,
  output logic       o_err_overflow
);

  import klotski_motion_pkg::cell_t;
  import klotski_motion_pkg::move_rec_t;
  import klotski_motion_pkg::state_t;
  import klotski_motion_pkg::S_IDLE;
  import klotski_motion_pkg::S_CARRY;
  import klotski_motion_pkg::S_PUSH;
  import klotski_motion_pkg::cell_of;

  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  logic [XW-1:0] col_next;
  logic [YW-1:0] row_next;
  logic          x_range_err, y_range_err;

  step_axis_tracker #(
    .STEPS_PER_CELL(STEPS_PER_CELL),
    .NCELLS        (COLS),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_axis_x (
    .i_Clk       (i_Clk),
    .i_rst_n     (i_rst_n),
    .step_i      (i_step_x),
    .dir_i       (i_direction_x),
    .clear_i     (i_clear),
    .coord_next_o(col_next),
    .range_err_o (x_range_err)
  );

  step_axis_tracker #(
    .STEPS_PER_CELL(STEPS_PER_CELL),
    .NCELLS        (ROWS),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_axis_y (
    .i_Clk       (i_Clk),
    .i_rst_n     (i_rst_n),
    .step_i      (i_step_y),
    .dir_i       (i_direction_y),
    .clear_i     (i_clear),
    .coord_next_o(row_next),
    .range_err_o (y_range_err)
  );

  logic [SYNC_STAGES-1:0] mag_sync_q;
  logic                   mag_prev_q;
  logic                   mag_rise, mag_fall;
  cell_t                  cell_q, cell_d;
  cell_t                  start_q;
  state_t                 state_q;
  logic                   carrying_q;
  logic                   err_range_q, err_ovf_q;

  assign mag_rise = mag_sync_q[SYNC_STAGES-1] & ~mag_prev_q;
  assign mag_fall = ~mag_sync_q[SYNC_STAGES-1] & mag_prev_q;
  assign cell_d   = cell_of(int'(row_next), int'(col_next), COLS);

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mag_sync_q  <= '0;
      mag_prev_q  <= 1'b0;
      cell_q      <= '0;
      err_range_q <= 1'b0;
    end else begin
      mag_sync_q  <= (mag_sync_q << 1) | SYNC_STAGES'(i_magnet);
      mag_prev_q  <= mag_sync_q[SYNC_STAGES-1];
      cell_q      <= cell_d;
      if (i_clear) begin
        err_range_q <= 1'b0;
      end else if (x_range_err || y_range_err) begin
        err_range_q <= 1'b1;
      end
    end
  end

  // S_PUSH sees cell_q already updated by a step landing with the magnet fall.
  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      start_q    <= '0;
      carrying_q <= 1'b0;
    end else if (i_clear) begin
      state_q    <= S_IDLE;
      carrying_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mag_rise) begin
            start_q    <= cell_q;
            state_q    <= S_CARRY;
            carrying_q <= 1'b1;
          end
        end
        S_CARRY: begin
          if (mag_fall) begin
            state_q    <= S_PUSH;
            carrying_q <= 1'b0;
          end
        end
        S_PUSH: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          carrying_q <= 1'b0;
        end
      endcase
    end
  end

  move_rec_t         mem_q [FIFO_DEPTH];
  move_rec_t         push_rec, head_q, head_d;
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic              push, pop, full, push_ok, overflow;

  assign push     = (state_q == S_PUSH) && !i_clear;
  assign push_rec = '{start_cell: start_q, end_cell: cell_q};

  always_comb begin
    pop      = (cnt_q != '0) && i_move_ready;
    full     = (cnt_q == NW'(FIFO_DEPTH));
    push_ok  = push && (!full || pop);
    overflow = push && full && !pop;
    wr_d     = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d     = pop ? rd_q + 1'b1 : rd_q;
    cnt_d    = cnt_q;
    if (push_ok && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push_ok && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
    // The new head is the record being written when it lands in the head slot.
    head_d = '0;
    if (cnt_d != '0) begin
      head_d = (push_ok && (rd_d == wr_q)) ? push_rec : mem_q[rd_d];
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= push_rec;
    end
  end

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      head_q    <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      if (i_clear) begin
        err_ovf_q <= 1'b0;
      end else if (overflow) begin
        err_ovf_q <= 1'b1;
      end
    end
  end

  assign o_cell         = cell_q;
  assign o_carrying     = carrying_q;
  assign o_move_valid   = (cnt_q != '0);
  assign o_move_start   = head_q.start_cell;
  assign o_move_end     = head_q.end_cell;
  assign o_err_range    = err_range_q;
  assign o_err_overflow = err_ovf_q;

endmodule
